// File: rtl/jt6295_adpcm.sv
// Four-channel time-multiplexed OKI ADPCM decoder.
// A two-stage pipeline per slot strobe: S1 latches the channel state, S2 writes it back and emits the sample.
module jt6295_adpcm (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen_sr,
  input  logic              cen_sr4,
  input  logic [3:0]        ch_on,
  input  logic [3:0]        ch_start,
  input  logic [3:0]        nibble_in,
  output logic [1:0]        slot,
  output logic signed [11:0] snd,
  output logic [1:0]        snd_ch,
  output logic              snd_valid
);

  function automatic logic [10:0] step_rom(input logic [5:0] i);
    case (i)
      6'd0:  step_rom = 11'd16;   6'd1:  step_rom = 11'd17;   6'd2:  step_rom = 11'd19;
      6'd3:  step_rom = 11'd21;   6'd4:  step_rom = 11'd23;   6'd5:  step_rom = 11'd25;
      6'd6:  step_rom = 11'd28;   6'd7:  step_rom = 11'd31;   6'd8:  step_rom = 11'd34;
      6'd9:  step_rom = 11'd37;   6'd10: step_rom = 11'd41;   6'd11: step_rom = 11'd45;
      6'd12: step_rom = 11'd50;   6'd13: step_rom = 11'd55;   6'd14: step_rom = 11'd60;
      6'd15: step_rom = 11'd66;   6'd16: step_rom = 11'd73;   6'd17: step_rom = 11'd80;
      6'd18: step_rom = 11'd88;   6'd19: step_rom = 11'd97;   6'd20: step_rom = 11'd107;
      6'd21: step_rom = 11'd118;  6'd22: step_rom = 11'd130;  6'd23: step_rom = 11'd143;
      6'd24: step_rom = 11'd157;  6'd25: step_rom = 11'd173;  6'd26: step_rom = 11'd190;
      6'd27: step_rom = 11'd209;  6'd28: step_rom = 11'd230;  6'd29: step_rom = 11'd253;
      6'd30: step_rom = 11'd279;  6'd31: step_rom = 11'd307;  6'd32: step_rom = 11'd337;
      6'd33: step_rom = 11'd371;  6'd34: step_rom = 11'd408;  6'd35: step_rom = 11'd449;
      6'd36: step_rom = 11'd494;  6'd37: step_rom = 11'd544;  6'd38: step_rom = 11'd598;
      6'd39: step_rom = 11'd658;  6'd40: step_rom = 11'd724;  6'd41: step_rom = 11'd796;
      6'd42: step_rom = 11'd876;  6'd43: step_rom = 11'd963;  6'd44: step_rom = 11'd1060;
      6'd45: step_rom = 11'd1166; 6'd46: step_rom = 11'd1282; 6'd47: step_rom = 11'd1411;
      default: step_rom = 11'd1552;
    endcase
  endfunction

  logic signed [11:0] sig_mem [4];
  logic [5:0]         idx_mem [4];

  logic               s1_valid, s1_on;
  logic [1:0]         s1_ch;
  logic [3:0]         s1_nib;
  logic signed [11:0] s1_sig;
  logic [5:0]         s1_idx;
  logic [10:0]        s1_step;

  logic [1:0]         cur_ch;
  logic signed [11:0] cur_sig;
  logic [5:0]         cur_idx;

  logic [11:0]        d;
  logic signed [13:0] sig_ext, d_ext, sum;
  logic signed [11:0] new_sig;
  logic signed [6:0]  idx_delta, idx_sum;
  logic [5:0]         new_idx;

  // A clear arriving on the latch edge is forwarded so S1 never picks up stale state.
  always_comb begin
    cur_ch  = cen_sr ? 2'd0 : slot;
    cur_sig = ch_start[cur_ch] ? 12'sd0 : sig_mem[cur_ch];
    cur_idx = ch_start[cur_ch] ? 6'd0   : idx_mem[cur_ch];
  end

  // Extra headroom past 13b keeps signal+d from wrapping before the clamp.
  always_comb begin
    d = {4'b0, s1_step[10:3]}
      + (s1_nib[2] ? {1'b0, s1_step} : 12'd0)
      + (s1_nib[1] ? {2'b0, s1_step[10:1]} : 12'd0)
      + (s1_nib[0] ? {3'b0, s1_step[10:2]} : 12'd0);
    sig_ext = {{2{s1_sig[11]}}, s1_sig};
    d_ext   = {2'b00, d};
    sum     = s1_nib[3] ? (sig_ext - d_ext) : (sig_ext + d_ext);
    if (sum > 14'sd2047)       new_sig = 12'sd2047;
    else if (sum < -14'sd2048) new_sig = -12'sd2048;
    else                       new_sig = sum[11:0];

    case (s1_nib[2:0])
      3'd4:    idx_delta = 7'sd2;
      3'd5:    idx_delta = 7'sd4;
      3'd6:    idx_delta = 7'sd6;
      3'd7:    idx_delta = 7'sd8;
      default: idx_delta = -7'sd1;
    endcase
    idx_sum = $signed({1'b0, s1_idx}) + idx_delta;
    if (idx_sum < 7'sd0)       new_idx = 6'd0;
    else if (idx_sum > 7'sd48) new_idx = 6'd48;
    else                       new_idx = idx_sum[5:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot      <= 2'd0;
      snd       <= 12'sd0;
      snd_ch    <= 2'd0;
      snd_valid <= 1'b0;
      s1_valid  <= 1'b0;
      s1_on     <= 1'b0;
      s1_ch     <= 2'd0;
      s1_nib    <= 4'd0;
      s1_sig    <= 12'sd0;
      s1_idx    <= 6'd0;
      s1_step   <= 11'd0;
      for (int n = 0; n < 4; n++) begin
        sig_mem[n] <= 12'sd0;
        idx_mem[n] <= 6'd0;
      end
    end else begin
      snd_valid <= 1'b0;
      s1_valid  <= cen_sr4;
      if (cen_sr4) begin
        slot    <= cur_ch + 2'd1;
        s1_ch   <= cur_ch;
        s1_on   <= ch_on[cur_ch];
        s1_nib  <= nibble_in;
        s1_sig  <= cur_sig;
        s1_idx  <= cur_idx;
        s1_step <= step_rom(cur_idx);
      end
      if (s1_valid) begin
        snd_valid <= 1'b1;
        snd_ch    <= s1_ch;
        snd       <= s1_on ? new_sig : 12'sd0;
        if (s1_on) begin
          sig_mem[s1_ch] <= new_sig;
          idx_mem[s1_ch] <= new_idx;
        end
      end
      // Placed after the write-back so a coincident clear takes precedence.
      for (int n = 0; n < 4; n++) begin
        if (ch_start[n]) begin
          sig_mem[n] <= 12'sd0;
          idx_mem[n] <= 6'd0;
        end
      end
    end
  end

endmodule
